shared_adder_arbiter: RTL and testbench

//  Shares one N-bit carry_select_adder among NREQ requesters (ODE stage units) with round-robin arbitration.

---
 rtl/shared_adder_arbiter.sv | 148 ++++++++++++++
 tb/tb_shared_adder_arbiter.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/shared_adder_arbiter.sv
// Round-robin arbiter that time-shares one carry-select adder among NREQ
// requesters and returns results on a single tagged response channel.

module carry_select_adder #(
  parameter int N = 16
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  output logic [N-1:0] sum,
  output logic         cout,
  output logic         c_msb
);
  localparam int H = N / 2;

  logic [H:0]   lo;
  logic [H-1:0] mid0;
  logic [H-1:0] mid1;
  logic [H-1:0] mid;
  logic         top;

  // Upper half (minus the sign bit) is precomputed for both carry-ins;
  // the lower-half carry picks one. The sign bit is kept separate so the
  // carry into it is available for overflow detection.
  assign lo    = {1'b0, a[H-1:0]} + {1'b0, b[H-1:0]} + {{H{1'b0}}, cin};
  assign mid0  = {1'b0, a[N-2:H]} + {1'b0, b[N-2:H]};
  assign mid1  = {1'b0, a[N-2:H]} + {1'b0, b[N-2:H]} + {{(H-1){1'b0}}, 1'b1};
  assign mid   = lo[H] ? mid1 : mid0;
  assign c_msb = mid[H-1];
  assign top   = a[N-1] ^ b[N-1] ^ c_msb;
  assign cout  = (a[N-1] & b[N-1]) | (c_msb & (a[N-1] ^ b[N-1]));
  assign sum   = {top, mid[H-2:0], lo[H-1:0]};
endmodule

module shared_adder_arbiter #(
  parameter int N    = 16,
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*N-1:0] req_a,
  input  logic [NREQ*N-1:0] req_b,
  input  logic [NREQ-1:0]   req_sub,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [IDW-1:0]    rsp_id,
  output logic [N-1:0]      rsp_result,
  output logic              rsp_carry,
  output logic              rsp_overflow,
  output logic              rsp_negative
);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t         state;
  state_t         state_nxt;
  logic [IDW-1:0] ptr;
  logic [IDW-1:0] cand;
  logic [IDW-1:0] gidx;
  logic           found;
  logic           can_grant;
  logic           accept;

  logic [N-1:0]   op_a;
  logic [N-1:0]   op_b;
  logic           op_sub;
  logic [IDW-1:0] op_id;

  logic [N-1:0]   b_eff;
  logic [N-1:0]   sum;
  logic           cout;
  logic           c_msb;

  // Search starts just after the last winner so every requester gets a turn.
  always_comb begin
    found = 1'b0;
    gidx  = '0;
    cand  = '0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = IDW'((int'(ptr) + k) % NREQ);
      if (!found && req_valid[cand]) begin
        found = 1'b1;
        gidx  = cand;
      end
    end
  end

  assign can_grant = rst_n && ((state == IDLE) || ((state == DONE) && rsp_ready));
  assign accept    = can_grant && found;
  assign req_ready = accept ? (NREQ'(1) << gidx) : '0;
  assign rsp_valid = (state == DONE);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (found) state_nxt = BUSY;
      BUSY:    state_nxt = DONE;
      DONE:    if (rsp_ready) state_nxt = found ? BUSY : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign b_eff = op_sub ? ~op_b : op_b;

  carry_select_adder #(.N(N)) u_adder (
    .a     (op_a),
    .b     (b_eff),
    .cin   (op_sub),
    .sum   (sum),
    .cout  (cout),
    .c_msb (c_msb)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      ptr          <= IDW'(NREQ - 1);
      op_a         <= '0;
      op_b         <= '0;
      op_sub       <= 1'b0;
      op_id        <= '0;
      rsp_id       <= '0;
      rsp_result   <= '0;
      rsp_carry    <= 1'b0;
      rsp_overflow <= 1'b0;
      rsp_negative <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        op_a   <= req_a[int'(gidx)*N +: N];
        op_b   <= req_b[int'(gidx)*N +: N];
        op_sub <= req_sub[gidx];
        op_id  <= gidx;
        ptr    <= gidx;
      end
      // Negative is the true sign: the wrapped sign bit corrected by overflow.
      if (state == BUSY) begin
        rsp_id       <= op_id;
        rsp_result   <= sum;
        rsp_carry    <= cout;
        rsp_overflow <= c_msb ^ cout;
        rsp_negative <= (c_msb ^ cout) ^ sum[N-1];
      end
    end
  end
endmodule

// File: tb/tb_shared_adder_arbiter.sv
// Scoreboard bench for shared_adder_arbiter: directed requests push hand-computed
// responses into a queue that an independent monitor pops on each response handshake.

module tb_shared_adder_arbiter;
  localparam int N    = 16;
  localparam int NREQ = 4;
  localparam int IDW  = 2;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*N-1:0] req_a;
  logic [NREQ*N-1:0] req_b;
  logic [NREQ-1:0]   req_sub;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [IDW-1:0]    rsp_id;
  logic [N-1:0]      rsp_result;
  logic              rsp_carry;
  logic              rsp_overflow;
  logic              rsp_negative;

  typedef struct packed {
    logic [IDW-1:0] id;
    logic [N-1:0]   res;
    logic           c;
    logic           v;
    logic           n;
  } exp_t;

  typedef struct {
    int          who;
    logic [15:0] a;
    logic [15:0] b;
    logic        sub;
    logic [15:0] res;
    logic        c;
    logic        v;
    logic        n;
  } vec_t;

  exp_t exp_q[$];
  exp_t mon_e;
  vec_t vecs[0:5];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  shared_adder_arbiter #(.N(N), .NREQ(NREQ), .IDW(IDW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_a        (req_a),
    .req_b        (req_b),
    .req_sub      (req_sub),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_id       (rsp_id),
    .rsp_result   (rsp_result),
    .rsp_carry    (rsp_carry),
    .rsp_overflow (rsp_overflow),
    .rsp_negative (rsp_negative)
  );

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("[TB] FAIL %s: got=0x%0h want=0x%0h", name, act, want);
    end
  endtask

  // Monitor: every accepted response must match the oldest expected entry.
  always @(negedge clk) begin
    if (rst_n && rsp_valid && rsp_ready) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("[TB] FAIL unexpected_rsp: got id=%0d result=0x%0h want no response", rsp_id, rsp_result);
      end else begin
        mon_e = exp_q.pop_front();
        check_output("rsp_id", 32'(rsp_id), 32'(mon_e.id));
        check_output("rsp_result", 32'(rsp_result), 32'(mon_e.res));
        check_output("rsp_flags_cvn", 32'({rsp_carry, rsp_overflow, rsp_negative}),
                     32'({mon_e.c, mon_e.v, mon_e.n}));
      end
    end
  end

  task automatic set_req(input int who, input logic [N-1:0] a, input logic [N-1:0] b, input logic sub);
    req_a[who*N +: N] = a;
    req_b[who*N +: N] = b;
    req_sub[who]      = sub;
  endtask

  task automatic push_exp(input int who, input logic [N-1:0] res, input logic c, input logic v, input logic n);
    exp_t e;
    e.id  = IDW'(who);
    e.res = res;
    e.c   = c;
    e.v   = v;
    e.n   = n;
    exp_q.push_back(e);
  endtask

  // Returns on the negedge where a grant is visible; the accept follows at the next posedge.
  task automatic wait_grant(input int who, input string name);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (req_ready == '0 && n < 20);
    check_output(name, 32'(req_ready), 32'(1) << who);
  endtask

  task automatic wait_rsp(input string name);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!rsp_valid && n < 20);
    check_output(name, 32'(rsp_valid), 32'd1);
  endtask

  task automatic drain(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    check_output(name, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic apply_stimulus(input vec_t v, input string name);
    @(posedge clk);
    #1;
    set_req(v.who, v.a, v.b, v.sub);
    req_valid[v.who] = 1'b1;
    wait_grant(v.who, name);
    push_exp(v.who, v.res, v.c, v.v, v.n);
    @(posedge clk);
    #1;
    req_valid[v.who] = 1'b0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: got=running want=finished");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    int last;
    vecs[0] = '{1, 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0};
    vecs[1] = '{2, 16'h0000, 16'h0001, 1'b1, 16'hFFFF, 1'b0, 1'b0, 1'b1};
    vecs[2] = '{3, 16'h0005, 16'h0003, 1'b1, 16'h0002, 1'b1, 1'b0, 1'b0};
    vecs[3] = '{0, 16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b1};
    vecs[4] = '{1, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0};
    vecs[5] = '{3, 16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 1'b0, 1'b0};

    rst_n     = 1'b0;
    req_valid = 4'b0101;
    req_a     = '0;
    req_b     = '0;
    req_sub   = '0;
    rsp_ready = 1'b1;
    repeat (2) @(negedge clk);
    check_output("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check_output("rst_req_ready", 32'(req_ready), 32'd0);
    check_output("rst_rsp_result", 32'(rsp_result), 32'd0);
    @(posedge clk);
    #1;
    req_valid = '0;
    rst_n     = 1'b1;

    // Single add and its two-edge latency.
    @(posedge clk);
    #1;
    set_req(0, 16'h0003, 16'h0004, 1'b0);
    req_valid[0] = 1'b1;
    wait_grant(0, "t2_grant");
    push_exp(0, 16'h0007, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    req_valid[0] = 1'b0;
    @(negedge clk);
    check_output("t2_busy_no_valid", 32'(rsp_valid), 32'd0);
    @(negedge clk);
    check_output("t2_done_valid", 32'(rsp_valid), 32'd1);

    // Flag boundaries and back-to-back grants from DONE.
    for (int i = 0; i < 6; i++) apply_stimulus(vecs[i], "t3_grant");
    drain("t3_drain");

    // Response stall: outputs hold, no grants, regrant in the release cycle.
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    apply_stimulus('{1, 16'h1234, 16'h1111, 1'b0, 16'h2345, 1'b0, 1'b0, 1'b0}, "t5_grant");
    wait_rsp("t5_valid");
    @(posedge clk);
    #1;
    set_req(3, 16'h0010, 16'h0020, 1'b1);
    req_valid[3] = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_output("t5_hold_valid", 32'(rsp_valid), 32'd1);
      check_output("t5_hold_result", 32'(rsp_result), 32'h2345);
      check_output("t5_hold_id", 32'(rsp_id), 32'd1);
      check_output("t5_hold_no_grant", 32'(req_ready), 32'd0);
    end
    @(posedge clk);
    #1;
    rsp_ready = 1'b1;
    @(negedge clk);
    check_output("t5_regrant", 32'(req_ready), 32'b1000);
    push_exp(3, 16'hFFF0, 1'b0, 1'b0, 1'b1);
    @(posedge clk);
    #1;
    req_valid[3] = 1'b0;
    drain("t5_drain");

    // Asynchronous reset while a response is pending.
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    set_req(1, 16'h7FFF, 16'h0001, 1'b0);
    req_valid[1] = 1'b1;
    wait_grant(1, "t1_grant");
    @(posedge clk);
    #1;
    req_valid[1] = 1'b0;
    wait_rsp("t1_valid");
    check_output("t1_pre_result", 32'(rsp_result), 32'h8000);
    #2;
    rst_n = 1'b0;
    #1;
    check_output("t1_async_valid", 32'(rsp_valid), 32'd0);
    check_output("t1_async_result", 32'(rsp_result), 32'd0);
    check_output("t1_async_id", 32'(rsp_id), 32'd0);
    check_output("t1_async_ovf", 32'(rsp_overflow), 32'd0);
    check_output("t1_async_ready", 32'(req_ready), 32'd0);
    @(posedge clk);
    #1;
    rst_n     = 1'b1;
    rsp_ready = 1'b1;

    // Round robin with everyone valid: order 0,1,2,3,0 at one grant per two cycles.
    for (int i = 0; i < NREQ; i++) set_req(i, N'((i + 1) * 256), N'(i + 1), 1'b0);
    req_valid = 4'b1111;
    last = 0;
    for (int g = 0; g < 5; g++) begin
      wait_grant(g % NREQ, "t4_rr_grant");
      push_exp(g % NREQ, N'(((g % NREQ) + 1) * 16'h0101), 1'b0, 1'b0, 1'b0);
      if (g > 0) check_output("t4_gap", 32'(cyc - last), 32'd2);
      last = cyc;
    end
    @(posedge clk);
    #1;
    req_valid = '0;
    drain("t4_drain");

    // Reset during BUSY drops the in-flight op and restarts the pointer.
    @(posedge clk);
    #1;
    set_req(2, 16'h0002, 16'h0003, 1'b0);
    req_valid[2] = 1'b1;
    wait_grant(2, "t6_grant");
    @(posedge clk);
    #1;
    req_valid[2] = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check_output("t6_rst_valid", 32'(rsp_valid), 32'd0);
    repeat (2) begin
      @(negedge clk);
      check_output("t6_rst_hold", 32'(rsp_valid), 32'd0);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    set_req(0, 16'h0011, 16'h0022, 1'b0);
    set_req(2, 16'h0100, 16'h0001, 1'b1);
    req_valid = 4'b0101;
    wait_grant(0, "t6_first_req0");
    push_exp(0, 16'h0033, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    req_valid[0] = 1'b0;
    wait_grant(2, "t6_second_req2");
    push_exp(2, 16'h00FF, 1'b1, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    req_valid[2] = 1'b0;
    drain("t6_drain");

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
